pushbutton_irq_sequencer: RTL and testbench
===========================================

Name: pushbutton_irq_sequencer

Overview:
- Avalon-MM master that owns the pushbutton parallel-port slave (4 keys, registers: 0 = level, 2 = interrupt mask, 3 = edge capture).
- Programs the mask, services the port IRQ (read capture, clear capture, read level) and pushes timestamped-free key events into a small FIFO with a valid/ready stream interface.
- Sits between the port and the application logic, replacing CPU interrupt handling for key events.

Parameters:
- DW, 3, data width minus 1 (key count minus 1); matches the port's DW.
- FIFO_DEPTH, 4, event FIFO entries; power of 2, minimum 2.
- GUARD_CYC, 2, idle cycles after a capture clear before irq_in is sampled again; covers the port's registered irq.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = service interrupts; 0 = stay in IDLE after any in-progress sequence completes.
- cfg_mask  in  DW+1  desired interrupt mask; any change is re-written to the port.
- m_address  out  2  port register address.
- m_chipselect  out  1  port chipselect.
- m_read  out  1  read strobe.
- m_write  out  1  write strobe.
- m_byteenable  out  4  always 4'hF while m_chipselect = 1, else 0.
- m_writedata  out  32  write data.
- m_readdata  in  32  port read data; fixed latency of 1 cycle after the chipselect cycle.
- irq_in  in  1  port interrupt.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head entry when evt_valid & evt_ready.
- evt_data  out  2*(DW+1)  {level[DW:0], edges[DW:0]} of the head entry.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, reset_n = 0): all m_* outputs = 0, FIFO empty, evt_valid = 0, busy = 1 after release, mask shadow = 0. The FSM enters INIT_MASK on the first clock after release.
- Bus strobes are single-cycle and registered; at most one access is in flight.
- FSM states and transitions:
  - INIT_MASK: 1 cycle, cs = 1, write = 1, address = 2, writedata = zero-extended cfg_mask; shadow <= cfg_mask. Then GUARD.
  - IDLE: priority order is (1) cfg_mask != shadow -> INIT_MASK; (2) enable & irq_in & FIFO not full -> RD_CAP; (3) otherwise stay.
  - RD_CAP: cs = 1, read = 1, address = 3. Then WAIT_CAP.
  - WAIT_CAP: edges <= m_readdata[DW:0]. Then CLR_CAP.
  - CLR_CAP: cs = 1, write = 1, address = 3, writedata = 0. Then RD_DAT.
  - RD_DAT: cs = 1, read = 1, address = 0. Then WAIT_DAT.
  - WAIT_DAT: level <= m_readdata[DW:0]. Then PUSH.
  - PUSH: if edges != 0, write {level, edges} to the FIFO; if edges == 0 (spurious), push nothing. Then GUARD.
  - GUARD: count GUARD_CYC cycles, then IDLE. irq_in is ignored during GUARD.
- Service latency: irq_in high in IDLE -> FIFO write on the 6th following edge; evt_valid rises 1 cycle after the FIFO write.
- FIFO is full: the port is not serviced. Edges keep OR-accumulating in the port capture register, so events are coalesced, never dropped.
- FIFO simultaneous push and pop: both take effect; the count is unchanged.
- cfg_mask changing mid-sequence: the sequence completes, then IDLE routes to INIT_MASK.
- enable deasserted mid-sequence: the sequence completes; the event is pushed.
- Edge arriving between RD_CAP and CLR_CAP: lost by the port hardware. This is accepted behaviour; no recovery is attempted.
- Reset asserted mid-operation: immediate return to the reset state; the FIFO content is discarded.

Decomposition:
- Shared package pb_pkg:
  - register addresses PB_ADDR_DATA = 0, PB_ADDR_MASK = 2, PB_ADDR_CAPT = 3;
  - FSM state enum;
  - event field offsets.
- Sub-module pb_event_fifo: synchronous FIFO (width 2*(DW+1), depth FIFO_DEPTH) with push, pop, full, empty and an async active-low reset.

Test Plan:
- Reset release with cfg_mask = 4'b1111 -> exactly one write of addr 2 with data 0x0000000F; busy drops after the GUARD cycles; evt_valid = 0.
- Behavioural port model, key1 pressed -> capture 4'b0010 and irq -> bus sequence is read 3, write 3 (data 0), read 0; FIFO entry {level = 4'b0010, edges = 4'b0010}; evt_valid rises 7 cycles after irq.
- evt_ready held at 0, 5 separate presses on key0 -> 4 entries stored, FIFO full. The 5th press stays in capture. On the first pop, a 5th entry with edges = 4'b0001 is pushed.
- Spurious irq with capture = 0 -> full bus sequence runs, no FIFO push, evt_valid stays 0.
- cfg_mask changed 4'b1111 -> 4'b0001 during WAIT_CAP -> the sequence finishes and pushes, then a write of addr 2 with data 0x1 occurs before the next service.
- reset_n pulsed low during CLR_CAP -> all strobes drop immediately, FIFO empty, INIT_MASK re-executes after release.

Source files
------------

// File: rtl/pb_pkg.sv
// Shared definitions for the pushbutton IRQ sequencer: port register map,
// sequencer state encoding and event word layout.
package pb_pkg;

  localparam logic [1:0] PB_ADDR_DATA = 2'd0;
  localparam logic [1:0] PB_ADDR_MASK = 2'd2;
  localparam logic [1:0] PB_ADDR_CAPT = 2'd3;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_INIT_MASK,
    ST_IDLE,
    ST_RD_CAP,
    ST_WAIT_CAP,
    ST_CLR_CAP,
    ST_RD_DAT,
    ST_WAIT_DAT,
    ST_PUSH,
    ST_GUARD
  } pb_state_e;

  // Event word is {level[DW:0], edges[DW:0]}; edges occupy the low field.
  localparam int PB_EVT_EDGES_LSB = 0;

  function automatic int pb_evt_level_lsb(input int dw);
    return dw + 1;
  endfunction

endpackage

// File: rtl/pb_event_fifo.sv
// Show-ahead synchronous FIFO holding key events; the head entry is always
// visible on rdata_o while empty_o is low.
module pb_event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/pushbutton_irq_sequencer.sv
// Avalon-MM master that programs the pushbutton port mask, services its IRQ
// (read capture, clear capture, read level) and queues key events.
module pushbutton_irq_sequencer
  import pb_pkg::*;
#(
  parameter int DW         = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int GUARD_CYC  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [DW:0]         cfg_mask,
  output logic [1:0]          m_address,
  output logic                m_chipselect,
  output logic                m_read,
  output logic                m_write,
  output logic [3:0]          m_byteenable,
  output logic [31:0]         m_writedata,
  input  logic [31:0]         m_readdata,
  input  logic                irq_in,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [2*(DW+1)-1:0] evt_data,
  output logic                busy
);

  localparam int EW            = 2 * (DW + 1);
  localparam int EVT_LEVEL_LSB = pb_evt_level_lsb(DW);
  localparam int GW            = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);

  pb_state_e     state_q;
  logic          cs_q;
  logic          rd_q;
  logic          wr_q;
  logic [1:0]    addr_q;
  logic [31:0]   wdata_q;
  logic [DW:0]   shadow_q;
  logic [DW:0]   edges_q;
  logic [DW:0]   level_q;
  logic [GW-1:0] guard_q;
  logic          push_q;
  logic          busy_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] evt_wdata;
  logic          unused_rd;

  assign unused_rd = ^m_readdata[31:DW+1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RESET;
      cs_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      edges_q  <= '0;
      level_q  <= '0;
      guard_q  <= '0;
      push_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      // Strobes are single-cycle: every access state re-arms them explicitly.
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      push_q  <= 1'b0;
      case (state_q)
        ST_RESET: begin
          state_q  <= ST_INIT_MASK;
          cs_q     <= 1'b1;
          wr_q     <= 1'b1;
          addr_q   <= PB_ADDR_MASK;
          wdata_q  <= 32'(cfg_mask);
          shadow_q <= cfg_mask;
        end
        ST_INIT_MASK: begin
          state_q <= ST_GUARD;
          guard_q <= '0;
        end
        ST_IDLE: begin
          if (cfg_mask != shadow_q) begin
            state_q  <= ST_INIT_MASK;
            cs_q     <= 1'b1;
            wr_q     <= 1'b1;
            addr_q   <= PB_ADDR_MASK;
            wdata_q  <= 32'(cfg_mask);
            shadow_q <= cfg_mask;
            busy_q   <= 1'b1;
          end else if (enable && irq_in && !fifo_full) begin
            state_q <= ST_RD_CAP;
            cs_q    <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= PB_ADDR_CAPT;
            busy_q  <= 1'b1;
          end
        end
        ST_RD_CAP: begin
          state_q <= ST_WAIT_CAP;
        end
        ST_WAIT_CAP: begin
          edges_q <= m_readdata[DW:0];
          state_q <= ST_CLR_CAP;
          cs_q    <= 1'b1;
          wr_q    <= 1'b1;
          addr_q  <= PB_ADDR_CAPT;
        end
        ST_CLR_CAP: begin
          state_q <= ST_RD_DAT;
          cs_q    <= 1'b1;
          rd_q    <= 1'b1;
          addr_q  <= PB_ADDR_DATA;
        end
        ST_RD_DAT: begin
          state_q <= ST_WAIT_DAT;
        end
        ST_WAIT_DAT: begin
          level_q <= m_readdata[DW:0];
          // An empty capture means the IRQ was spurious; nothing is queued.
          push_q  <= |edges_q;
          state_q <= ST_PUSH;
        end
        ST_PUSH: begin
          state_q <= ST_GUARD;
          guard_q <= '0;
        end
        ST_GUARD: begin
          if (guard_q == GUARD_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            guard_q <= guard_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_RESET;
        end
      endcase
    end
  end

  assign evt_wdata[EVT_LEVEL_LSB +: DW+1]    = level_q;
  assign evt_wdata[PB_EVT_EDGES_LSB +: DW+1] = edges_q;

  pb_event_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push_q),
    .wdata_i (evt_wdata),
    .pop_i   (evt_valid & evt_ready),
    .rdata_o (evt_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid    = ~fifo_empty;
  assign m_address    = addr_q;
  assign m_chipselect = cs_q;
  assign m_read       = rd_q;
  assign m_write      = wr_q;
  assign m_byteenable = {4{cs_q}};
  assign m_writedata  = wdata_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pushbutton_irq_sequencer.sv
// Directed bench: behavioural pushbutton port, bus and event scoreboards.
module tb_pushbutton_irq_sequencer;

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] data;
  } bus_op_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [3:0]  cfg_mask;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        irq_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_data;
  logic        busy;

  logic [3:0]  keys = 4'b0;
  logic [3:0]  keys_d = 4'b0;
  logic [3:0]  port_mask = 4'b0;
  logic [3:0]  port_cap = 4'b0;
  logic        port_irq = 1'b0;
  logic [31:0] port_rd = 32'b0;
  logic        spur = 1'b0;

  bus_op_t     exp_bus[$];
  logic [7:0]  exp_evt[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pushbutton_irq_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .cfg_mask     (cfg_mask),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .irq_in       (irq_in),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .busy         (busy)
  );

  // Behavioural parallel port: rising-edge capture, write to capture clears it,
  // registered irq and one-cycle read latency.
  always @(posedge clk) begin
    keys_d <= keys;
    if (m_chipselect && m_write && m_address == 2'd2) port_mask <= m_writedata[3:0];
    if (m_chipselect && m_write && m_address == 2'd3) port_cap <= 4'b0;
    else port_cap <= port_cap | (keys & ~keys_d);
    port_irq <= |(port_cap & port_mask);
    if (m_chipselect && m_read) begin
      case (m_address)
        2'd0:    port_rd <= {28'b0, keys};
        2'd2:    port_rd <= {28'b0, port_mask};
        2'd3:    port_rd <= {28'b0, port_cap};
        default: port_rd <= 32'b0;
      endcase
    end
  end

  assign m_readdata = port_rd;
  assign irq_in     = port_irq | spur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_r(input logic [1:0] a);
    bus_op_t op;
    op.addr = a; op.wr = 1'b0; op.data = 32'b0;
    exp_bus.push_back(op);
  endtask

  task automatic exp_w(input logic [1:0] a, input logic [31:0] d);
    bus_op_t op;
    op.addr = a; op.wr = 1'b1; op.data = d;
    exp_bus.push_back(op);
  endtask

  task automatic exp_service();
    exp_r(2'd3);
    exp_w(2'd3, 32'h0);
    exp_r(2'd0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_access(input logic [1:0] a, input logic w, input string tag);
    int n = 0;
    @(negedge clk);
    while (!(m_chipselect && m_address == a && m_write == w) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 40), 32'd1);
  endtask

  // Bus scoreboard: every chipselect cycle must match the next expected access.
  always @(negedge clk) begin
    if (m_chipselect) begin
      bus_op_t op;
      $display("bus %s addr=%0d wdata=%08h", m_write ? "WR" : "RD", m_address, m_writedata);
      check("bus_byteenable", 32'(m_byteenable), 32'hF);
      n_cmp++;
      assert (exp_bus.size() != 0)
      else begin
        n_fail++;
        $error("FAIL bus_unexpected: observed addr %0d write %0b required no access", m_address, m_write);
      end
      if (exp_bus.size() != 0) begin
        op = exp_bus.pop_front();
        check("bus_addr", 32'(m_address), 32'(op.addr));
        check("bus_write", 32'(m_write), 32'(op.wr));
        check("bus_read", 32'(m_read), 32'(!op.wr));
        if (op.wr) check("bus_wdata", m_writedata, op.data);
      end
    end
  end

  // Event scoreboard: compare head entry on each accepted handshake.
  always @(negedge clk) begin
    if (evt_valid && evt_ready) begin
      $display("evt level=%04b edges=%04b", evt_data[7:4], evt_data[3:0]);
      n_cmp++;
      assert (exp_evt.size() != 0)
      else begin
        n_fail++;
        $error("FAIL evt_unexpected: observed %02h required no event", evt_data);
      end
      if (exp_evt.size() != 0) check("evt_data", 32'(evt_data), 32'(exp_evt.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n   = 1'b0;
    enable    = 1'b1;
    cfg_mask  = 4'hF;
    evt_ready = 1'b1;
    step(3);

    // Reset state
    check("rst_cs", 32'(m_chipselect), 32'd0);
    check("rst_wr", 32'(m_write), 32'd0);
    check("rst_rd", 32'(m_read), 32'd0);
    check("rst_addr", 32'(m_address), 32'd0);
    check("rst_wdata", m_writedata, 32'd0);
    check("rst_be", 32'(m_byteenable), 32'd0);
    check("rst_valid", 32'(evt_valid), 32'd0);

    // Release: one mask write, then INIT + GUARD before idle
    exp_w(2'd2, 32'h0000000F);
    reset_n = 1'b1;
    n = 0;
    do begin step(1); n++; end while (busy !== 1'b0 && n < 20);
    check("init_busy_cycles", 32'(n), 32'd4);
    check("init_valid", 32'(evt_valid), 32'd0);
    check("init_bus_done", 32'(exp_bus.size()), 32'd0);

    // Key1 press: service sequence and event latency
    step(2);
    exp_service();
    exp_evt.push_back(8'b0010_0010);
    keys = 4'b0010;
    n = 0;
    while (irq_in !== 1'b1 && n < 10) begin step(1); n++; end
    check("k1_irq_seen", 32'(irq_in), 32'd1);
    n = 0;
    do begin step(1); n++; end while (evt_valid !== 1'b1 && n < 20);
    check("k1_evt_latency", 32'(n), 32'd7);
    keys = 4'b0;
    step(10);
    check("k1_idle", 32'(busy), 32'd0);
    check("k1_evt_done", 32'(exp_evt.size()), 32'd0);

    // FIFO fill: four stored, fifth coalesced in capture until a pop
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_service();
      exp_evt.push_back(i < 4 ? 8'b0001_0001 : 8'b0000_0001);
      keys = 4'b0001;
      step(12);
      keys = 4'b0;
      step(6);
    end
    step(10);
    check("full_irq_pending", 32'(irq_in), 32'd1);
    check("full_not_serviced", 32'(busy), 32'd0);
    check("full_valid", 32'(evt_valid), 32'd1);
    check("full_bus_pending", 32'(exp_bus.size()), 32'd3);
    evt_ready = 1'b1;
    step(40);
    check("drain_evt_done", 32'(exp_evt.size()), 32'd0);
    check("drain_bus_done", 32'(exp_bus.size()), 32'd0);
    check("drain_irq_clear", 32'(irq_in), 32'd0);

    // Spurious irq: full sequence, nothing queued
    evt_ready = 1'b0;
    exp_service();
    spur = 1'b1;
    step(1);
    spur = 1'b0;
    step(20);
    check("spur_valid", 32'(evt_valid), 32'd0);
    check("spur_bus_done", 32'(exp_bus.size()), 32'd0);
    check("spur_idle", 32'(busy), 32'd0);

    // Mask change during WAIT_CAP: sequence completes, then mask rewrite
    exp_service();
    exp_w(2'd2, 32'h1);
    exp_evt.push_back(8'b0100_0100);
    keys = 4'b0100;
    wait_access(2'd3, 1'b0, "mask_rdcap_seen");
    @(posedge clk);
    #1;
    cfg_mask = 4'b0001;
    step(8);
    keys = 4'b0;
    step(15);
    check("mask_bus_done", 32'(exp_bus.size()), 32'd0);
    check("mask_evt_held", 32'(evt_valid), 32'd1);
    check("mask_evt_head", 32'(evt_data), 32'h44);
    check("mask_idle", 32'(busy), 32'd0);

    // Reset during CLR_CAP: strobes drop, FIFO discarded, re-init then re-service
    exp_r(2'd3);
    exp_w(2'd3, 32'h0);
    keys = 4'b0001;
    step(2);
    keys = 4'b0;
    wait_access(2'd3, 1'b1, "rst_clrcap_seen");
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs", 32'(m_chipselect), 32'd0);
    check("mid_rst_wr", 32'(m_write), 32'd0);
    check("mid_rst_valid", 32'(evt_valid), 32'd0);
    exp_evt.delete();
    step(2);
    exp_w(2'd2, 32'h1);
    exp_service();
    exp_evt.push_back(8'b0000_0001);
    evt_ready = 1'b1;
    reset_n = 1'b1;
    step(30);
    check("rerun_bus_done", 32'(exp_bus.size()), 32'd0);
    check("rerun_evt_done", 32'(exp_evt.size()), 32'd0);
    check("rerun_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
